// File: rtl/lif_pkg.sv
// Shared constants, config addresses and FSM encoding for the LIF neuron scheduler.
// The optional refractory feature is enabled with LIF_SCHED_REFRACTORY_EN.
package lif_pkg;

   localparam int LIF_W          = 8;
   localparam int THRESH_DEFAULT = 200;
   localparam int LEAK_DEFAULT   = 1;
   localparam int RESETV_DEFAULT = 0;
   localparam int REFRAC_DEFAULT = 2;

   localparam logic [1:0] CFG_THRESH = 2'd0;
   localparam logic [1:0] CFG_LEAK   = 2'd1;
   localparam logic [1:0] CFG_RESETV = 2'd2;
   localparam logic [1:0] CFG_REFRAC = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } lif_state_e;

endpackage

// File: rtl/lif_update.sv
// Combinational leaky integrate-and-fire step for one neuron: leak, integrate,
// saturate to the membrane width, compare against threshold, reset on fire.
module lif_update import lif_pkg::*; #(
   parameter int W = LIF_W
) (
   input  logic [W-1:0] state_i,
   input  logic [W-1:0] cur_i,
   input  logic [W-1:0] leak_shift_i,
   input  logic [W-1:0] thresh_i,
   input  logic [W-1:0] reset_v_i,
   output logic [W-1:0] next_state_o,
   output logic         fire_o
);

   logic [W-1:0] leak_s;
   logic [W:0]   sum_s;
   logic [W-1:0] sat_s;

   // leak never exceeds the state, so the W+1 bit sum cannot underflow
   always_comb begin
      leak_s       = {W{1'b0}};
      sum_s        = {(W+1){1'b0}};
      sat_s        = {W{1'b0}};
      fire_o       = 1'b0;
      next_state_o = {W{1'b0}};
      if (leak_shift_i == {W{1'b0}}) begin
         leak_s = {W{1'b0}};
      end else begin
         leak_s = state_i >> leak_shift_i;
      end
      sum_s = {1'b0, state_i} - {1'b0, leak_s} + {1'b0, cur_i};
      if (sum_s[W]) begin
         sat_s = {W{1'b1}};
      end else begin
         sat_s = sum_s[W-1:0];
      end
      fire_o = (sat_s >= thresh_i);
      if (fire_o) begin
         next_state_o = reset_v_i;
      end else begin
         next_state_o = sat_s;
      end
   end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF scheduler: one neuron update per cycle per timestep tick,
// spikes leave through a one-entry valid/ready port. Macro LIF_SCHED_REFRACTORY_EN.
module lif_scheduler import lif_pkg::*; #(
   parameter int N_NEURONS = 8,
   parameter int W         = LIF_W,
   parameter int IDX_W     = $clog2(N_NEURONS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick_i,
   output logic [IDX_W-1:0] cur_idx_o,
   input  logic [W-1:0]     cur_i,
   input  logic             cfg_we_i,
   input  logic [1:0]       cfg_addr_i,
   input  logic [W-1:0]     cfg_data_i,
   output logic             spike_valid_o,
   output logic [IDX_W-1:0] spike_idx_o,
   input  logic             spike_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             overrun_o
);

   lif_state_e       fsm_q, fsm_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     mem_q [N_NEURONS];
   logic [W-1:0]     thresh_q, leak_q, resetv_q;
   logic             spike_valid_q, spike_valid_d;
   logic [IDX_W-1:0] spike_idx_q, spike_idx_d;
   logic             overrun_q, overrun_d;

   logic [W-1:0]     upd_next_s;
   logic             upd_fire_s, in_refrac_s, fire_s, stall_s, commit_s, last_s;

   lif_update #(.W(W)) u_update (
      .state_i      (mem_q[idx_q]),
      .cur_i        (cur_i),
      .leak_shift_i (leak_q),
      .thresh_i     (thresh_q),
      .reset_v_i    (resetv_q),
      .next_state_o (upd_next_s),
      .fire_o       (upd_fire_s)
   );

`ifdef LIF_SCHED_REFRACTORY_EN
   logic [3:0] refrac_q;
   logic [3:0] cnt_q [N_NEURONS];
   assign in_refrac_s = (cnt_q[idx_q] != 4'd0);
`else
   assign in_refrac_s = 1'b0;
`endif

   // a fire that cannot hand its spike over freezes the sweep on this neuron
   assign fire_s   = upd_fire_s & ~in_refrac_s;
   assign stall_s  = (fsm_q == ST_SWEEP) & fire_s & spike_valid_q & ~spike_ready_i;
   assign commit_s = (fsm_q == ST_SWEEP) & ~stall_s;
   assign last_s   = (idx_q == IDX_W'(N_NEURONS - 1));

   always_comb begin
      fsm_d     = fsm_q;
      idx_d     = idx_q;
      overrun_d = overrun_q;
      case (fsm_q)
         ST_IDLE: begin
            if (tick_i) begin
               fsm_d = ST_SWEEP;
               idx_d = {IDX_W{1'b0}};
            end else begin
               fsm_d = ST_IDLE;
            end
         end
         ST_SWEEP: begin
            if (commit_s && last_s) begin
               fsm_d = ST_DONE;
               idx_d = {IDX_W{1'b0}};
            end else if (commit_s) begin
               idx_d = idx_q + IDX_W'(1);
            end else begin
               idx_d = idx_q;
            end
         end
         ST_DONE: begin
            fsm_d = ST_IDLE;
         end
         default: begin
            fsm_d = ST_IDLE;
            idx_d = {IDX_W{1'b0}};
         end
      endcase
      if (tick_i && (fsm_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // loading a new spike takes priority; it also covers same-cycle accept + load
   always_comb begin
      spike_valid_d = spike_valid_q;
      spike_idx_d   = spike_idx_q;
      if (commit_s && fire_s) begin
         spike_valid_d = 1'b1;
         spike_idx_d   = idx_q;
      end else if (spike_valid_q && spike_ready_i) begin
         spike_valid_d = 1'b0;
      end else begin
         spike_valid_d = spike_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fsm_q         <= ST_IDLE;
         idx_q         <= {IDX_W{1'b0}};
         spike_valid_q <= 1'b0;
         spike_idx_q   <= {IDX_W{1'b0}};
         overrun_q     <= 1'b0;
      end else begin
         fsm_q         <= fsm_d;
         idx_q         <= idx_d;
         spike_valid_q <= spike_valid_d;
         spike_idx_q   <= spike_idx_d;
         overrun_q     <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            mem_q[i] <= {W{1'b0}};
         end
      end else if (commit_s && !in_refrac_s) begin
         mem_q[idx_q] <= upd_next_s;
      end
   end

   // configuration is only writable between sweeps
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         thresh_q <= W'(THRESH_DEFAULT);
         leak_q   <= W'(LEAK_DEFAULT);
         resetv_q <= W'(RESETV_DEFAULT);
`ifdef LIF_SCHED_REFRACTORY_EN
         refrac_q <= 4'(REFRAC_DEFAULT);
`endif
      end else if (cfg_we_i && (fsm_q == ST_IDLE)) begin
         case (cfg_addr_i)
            CFG_THRESH: thresh_q <= cfg_data_i;
            CFG_LEAK:   leak_q   <= cfg_data_i;
            CFG_RESETV: resetv_q <= cfg_data_i;
`ifdef LIF_SCHED_REFRACTORY_EN
            CFG_REFRAC: refrac_q <= cfg_data_i[3:0];
`endif
            default: ;
         endcase
      end
   end

`ifdef LIF_SCHED_REFRACTORY_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            cnt_q[i] <= 4'd0;
         end
      end else if (commit_s && in_refrac_s) begin
         cnt_q[idx_q] <= cnt_q[idx_q] - 4'd1;
      end else if (commit_s && fire_s) begin
         cnt_q[idx_q] <= refrac_q;
      end
   end
`endif

   assign cur_idx_o     = idx_q;
   assign spike_valid_o = spike_valid_q;
   assign spike_idx_o   = spike_idx_q;
   assign busy_o        = (fsm_q != ST_IDLE);
   assign done_o        = (fsm_q == ST_DONE);
   assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Bench for lif_scheduler: directed scenarios plus randomized sweeps checked
// against a per-timestep behavioural model of the neuron population.
module tb_lif_scheduler;

   localparam int N = 8;
   localparam int W = 8;

   logic       clk = 1'b0;
   logic       reset_n, tick_i, cfg_we_i, spike_ready_i;
   logic [1:0] cfg_addr_i;
   logic [7:0] cfg_data_i;
   logic [2:0] cur_idx_o, spike_idx_o;
   logic       spike_valid_o, busy_o, done_o, overrun_o;

   int cur_tab [N];
   wire [7:0] cur_i = 8'(cur_tab[cur_idx_o]);

   int checks = 0;
   int failures = 0;
   int ready_mode = 1;

   int m_state [N];
   int m_cnt [N];
   int m_thr, m_leak, m_rv, m_refrac;
   int exp_q [$];
   int got_q [$];
   int lat;

   always #5 clk = ~clk;

   lif_scheduler #(.N_NEURONS(N), .W(W)) dut (
      .clk(clk), .reset_n(reset_n), .tick_i(tick_i), .cur_idx_o(cur_idx_o), .cur_i(cur_i),
      .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
      .spike_valid_o(spike_valid_o), .spike_idx_o(spike_idx_o), .spike_ready_i(spike_ready_i),
      .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
   );

   always @(negedge clk) begin
      if (reset_n && spike_valid_o && spike_ready_i) got_q.push_back(int'(spike_idx_o));
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (ready_mode == 0) spike_ready_i = 1'($urandom_range(0, 1));
      else if (ready_mode == 1) spike_ready_i = 1'b1;
      else spike_ready_i = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_state[i] = 0;
         m_cnt[i] = 0;
      end
      m_thr = 200; m_leak = 1; m_rv = 0; m_refrac = 2;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic model_cfg(input int a, input int d);
      if (a == 0) m_thr = d;
      else if (a == 1) m_leak = d;
      else if (a == 2) m_rv = d;
`ifdef LIF_SCHED_REFRACTORY_EN
      else m_refrac = d % 16;
`endif
   endtask

   // one timestep of the whole population, spike order = neuron order
   task automatic model_sweep();
      for (int i = 0; i < N; i++) begin
         int lk, s;
`ifdef LIF_SCHED_REFRACTORY_EN
         if (m_cnt[i] > 0) begin
            m_cnt[i]--;
            continue;
         end
`endif
         lk = (m_leak == 0) ? 0 : (m_state[i] >> m_leak);
         s = m_state[i] - lk + cur_tab[i];
         if (s > 255) s = 255;
         if (s >= m_thr) begin
            exp_q.push_back(i);
            m_state[i] = m_rv;
            m_cnt[i] = m_refrac;
         end else begin
            m_state[i] = s;
         end
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0; tick_i = 1'b0; cfg_we_i = 1'b0;
      step(); step();
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic cfg_write(input int a, input int d);
      cfg_addr_i = 2'(a); cfg_data_i = 8'(d); cfg_we_i = 1'b1;
      step();
      cfg_we_i = 1'b0;
      model_cfg(a, d);
   endtask

   function automatic int mode_for(input int c, input int lo, input int hi, input int base);
      return (c >= lo && c <= hi) ? 2 : base;
   endfunction

   task automatic run_sweep(input int lo, input int hi, input int base, output int l);
      model_sweep();
      ready_mode = mode_for(1, lo, hi, base);
      tick_i = 1'b1;
      step();
      tick_i = 1'b0;
      l = 1;
      while (!done_o && l < 400) begin
         ready_mode = mode_for(l + 1, lo, hi, base);
         step();
         l++;
      end
      check_eq("done_seen", int'(done_o), 1);
      ready_mode = base;
      step();
      check_eq("busy_after_done", int'(busy_o), 0);
   endtask

   task automatic drain_compare(input string tag);
      int n = 0;
      ready_mode = 1;
      while (spike_valid_o && n < 50) begin
         step();
         n++;
      end
      check_eq({tag, "_drained"}, int'(spike_valid_o), 0);
      check_eq({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check_eq({tag, "_idx"}, got_q[i], exp_q[i]);
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      reset_n = 1'b0; tick_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = 2'd0; cfg_data_i = 8'd0;
      spike_ready_i = 1'b1;
      for (int i = 0; i < N; i++) cur_tab[i] = 0;

      do_reset();
      check_eq("rst_busy", int'(busy_o), 0);
      check_eq("rst_done", int'(done_o), 0);
      check_eq("rst_valid", int'(spike_valid_o), 0);
      check_eq("rst_overrun", int'(overrun_o), 0);
      check_eq("rst_cur_idx", int'(cur_idx_o), 0);

      // quiet sweep: latency N+1 to done
      run_sweep(0, -1, 1, lat);
      check_eq("quiet_latency", lat, N + 1);
      drain_compare("quiet");

      // single neuron charging over three timesteps
      cur_tab[3] = 120;
      for (int t = 0; t < 3; t++) begin
         run_sweep(0, -1, 1, lat);
         drain_compare("charge");
      end

      // every neuron fires, consumer blocks for 5 cycles
      do_reset();
      for (int i = 0; i < N; i++) cur_tab[i] = 255;
      run_sweep(2, 6, 1, lat);
      check_eq("stall_latency", lat, N + 6);
      drain_compare("stall");

      // saturation at the top of the range with leak disabled
      do_reset();
      for (int i = 0; i < N; i++) cur_tab[i] = 0;
      cfg_write(1, 0); cfg_write(0, 255); cfg_write(2, 5);
      cur_tab[0] = 250; run_sweep(0, -1, 1, lat); drain_compare("sat_a");
      cur_tab[0] = 255; run_sweep(0, -1, 1, lat); drain_compare("sat_b");
      cur_tab[0] = 0;   run_sweep(0, -1, 1, lat); drain_compare("sat_c");
      cur_tab[0] = 250; run_sweep(0, -1, 1, lat); drain_compare("sat_d");

      // tick and cfg write while busy are ignored
      do_reset();
      cur_tab[0] = 0; cur_tab[3] = 50;
      model_sweep();
      tick_i = 1'b1; step(); tick_i = 1'b0;
      step(); step();
      tick_i = 1'b1; cfg_addr_i = 2'd0; cfg_data_i = 8'd10; cfg_we_i = 1'b1;
      step();
      tick_i = 1'b0; cfg_we_i = 1'b0;
      lat = 0;
      while (!done_o && lat < 400) begin
         step();
         lat++;
      end
      check_eq("busy_done_seen", int'(done_o), 1);
      step();
      check_eq("overrun_set", int'(overrun_o), 1);
      drain_compare("busy_cfg");
      cfg_write(0, 10);
      run_sweep(0, -1, 1, lat);
      drain_compare("idle_cfg");
      check_eq("overrun_sticky", int'(overrun_o), 1);

      // reset while neuron 4 is evaluated and a spike is pending
      do_reset();
      for (int i = 0; i < N; i++) cur_tab[i] = 255;
      ready_mode = 1;
      tick_i = 1'b1; step(); tick_i = 1'b0;
      step(); step(); step();
      ready_mode = 2;
      step();
      check_eq("mid_cur_idx", int'(cur_idx_o), 4);
      check_eq("mid_pending", int'(spike_valid_o), 1);
      check_eq("mid_spike_idx", int'(spike_idx_o), 3);
      reset_n = 1'b0;
      ready_mode = 1;
      step();
      check_eq("abort_valid", int'(spike_valid_o), 0);
      check_eq("abort_busy", int'(busy_o), 0);
      check_eq("abort_cur_idx", int'(cur_idx_o), 0);
      check_eq("abort_overrun", int'(overrun_o), 0);
      reset_n = 1'b1;
      model_reset();
      run_sweep(0, -1, 1, lat);
      check_eq("after_abort_latency", lat, N + 1);
      drain_compare("after_abort");

      // randomized configurations, currents and consumer backpressure
      do_reset();
      for (int r = 0; r < 25; r++) begin
         if ($urandom_range(0, 2) == 0) begin
            int a = $urandom_range(0, 3);
            int d;
            if (a == 0) d = $urandom_range(60, 255);
            else if (a == 1) d = $urandom_range(0, 3);
            else if (a == 2) d = $urandom_range(0, 40);
            else d = $urandom_range(0, 5);
            cfg_write(a, d);
         end
         for (int i = 0; i < N; i++)
            cur_tab[i] = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 120);
         run_sweep(0, -1, 0, lat);
         drain_compare("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=1 expected=0");
      $fatal(1, "timeout");
   end

endmodule
